dmem_responder: RTL
===================

# dmem_responder

Memory-side responder for the pipelined CPU's data port. It accepts one load or store request at a time over a valid/ready handshake and services it against an internal byte-enabled word array after a programmable access latency. It returns every result, read data or write acknowledgement, over a second valid/ready channel. It sits between the CPU's MEM stage and on-chip data storage and replaces a combinational data memory once the pipeline gains memory stalls.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words stored; power of two, at least 4.
- LATENCY, 2: cycles from request acceptance to response valid; at least 1.

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- req_be  in  4  byte enables for stores; bit i selects wdata[8i+7:8i]
- rsp_valid  out  1  response present
- rsp_ready  in  1  requester accepts response
- rsp_rdata  out  32  load data; 0 for stores and errors
- rsp_err  out  1  request was misaligned or out of range

## Operation
- FSM has three states: IDLE, BUSY, RESP.
- IDLE: req_ready=1, rsp_valid=0.
  - When req_valid && req_ready at an edge, latch write, addr, wdata and be. Load cnt=LATENCY-1 and go to BUSY.
- BUSY: req_ready=0.
  - If cnt!=0, decrement cnt.
  - If cnt==0, perform the access at that edge, load rsp_rdata and rsp_err, and go to RESP.
- RESP: rsp_valid=1, outputs held stable.
  - When rsp_valid && rsp_ready at an edge, go to IDLE, clear rsp_valid, and set rsp_rdata=0 and rsp_err=0.
- Error rules:
  - addr[1:0]!=0 sets err.
  - Word index addr[31:2] >= DEPTH_WORDS sets err.
  - On err, no array write occurs and rdata=0.
- Store: bytes with be[i]=1 are written; other bytes keep their value. be=4'b0000 is a legal no-op with err=0. rdata=0.
- Load: the full word is returned and req_be is ignored.
- Request-side inputs are sampled only at the acceptance edge. Changes while req_ready=0 are ignored.

## Timing
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, cnt=0. The storage array is not reset.
- Latency: acceptance at edge T gives rsp_valid=1 after edge T+LATENCY.
- Minimum spacing between accepted requests is LATENCY+2 edges with rsp_ready held at 1:
  - accept at edge T;
  - response handshake at edge T+LATENCY+1;
  - req_ready=1 again after that edge;
  - next accept at edge T+LATENCY+2.
- No request acceptance occurs in the same cycle as a response handshake.
- rsp_ready=0 stalls in RESP indefinitely, with no timeout and outputs unchanged.
- Reset asserted mid-operation:
  - immediately returns the FSM to IDLE;
  - drops the pending request;
  - a store still in BUSY is never written;
  - array words written before reset keep their values.
- A store followed by a load to the same address returns the stored data, because the write completes before the store's response.

## Structure
- Package dmem_pkg holds:
  - state enum {IDLE, BUSY, RESP};
  - WORD_W=32 and BE_W=4;
  - ERR_NONE/ERR_SET constants;
  - a function word_index(addr) returning addr[31:2].
- Sub-module mem_word_array:
  - single-port, DEPTH_WORDS×32, synchronous byte-enabled write, combinational read;
  - instantiated once.
- The FSM, counter, request latch and error check live in dmem_responder.

## Test plan
- Reset: assert reset mid-BUSY on a store of 0xDEADBEEF to 0x10 with LATENCY=3. Require req_ready=1 and rsp_valid=0 immediately, and a later load of 0x10 returns the prior value (0 if pre-written with 0).
- Basic store/load: store 0x12345678 to 0x20 with be=1111, then load 0x20. Require rsp_valid exactly LATENCY cycles after each accept, store response rdata=0 and err=0, load rdata=0x12345678.
- Byte enables: after the previous test, store 0xAABBCCDD to 0x20 with be=0101, then load 0x20. Require rdata=0x12BB56DD. A store with be=0000 leaves the word unchanged and err=0.
- Errors:
  - load 0x22 gives err=1, rdata=0;
  - store to word index DEPTH_WORDS (0x400 at default) gives err=1 and no array change;
  - a load of 0x0 afterward returns its prior value.
- Backpressure: hold rsp_ready=0 for 10 cycles after a response. Require rsp_valid, rsp_rdata and rsp_err stable, req_ready=0, and new req_valid with different data ignored. Release rsp_ready and require req_ready=1 the following cycle.
- Throughput and latency sweep: run LATENCY=1 and LATENCY=4 with back-to-back requests and rsp_ready=1. Require accepts every LATENCY+2 edges, and a 64-request random read/write sequence matches a reference model.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  localparam logic ERR_NONE = 1'b0;
  localparam logic ERR_SET  = 1'b1;

  // Word index of a byte address (drops the byte-in-word offset).
  function automatic logic [29:0] word_index(input logic [31:0] addr);
    return addr[31:2];
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channel between the CPU MEM stage and the data responder.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the request and the response channel.
interface dmem_if;
  import dmem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [31:0]       req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WORD_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_word_array.sv
// Single-port word array with byte-enabled synchronous write.
// Latency: write lands at the clock edge, read is combinational.
// Backpressure: none; the caller decides when to write.
module mem_word_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [BE_W-1:0]   i_be,
  input  logic [AW-1:0]     i_idx,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);

  // Storage is deliberately not reset so it survives a responder reset.
  logic [WORD_W-1:0] r_mem [DEPTH_WORDS];

  // Byte-lane write: only enabled lanes are updated.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (i_be[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dmem_responder.sv
// Accepts one load/store at a time and answers it from the word array.
// Latency: response valid LATENCY cycles after acceptance; one request in flight.
// Backpressure: req_ready low from acceptance until the response handshake; rsp_ready low stalls in RESP.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic  clk,
  input  logic  reset,
  dmem_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic              r_write;
  logic [31:0]       r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic [BE_W-1:0]   r_be;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic [WORD_W-1:0] r_rdata;
  logic              r_err;

  logic [29:0]       w_widx;
  logic              w_err;
  logic              w_access;
  logic              w_we;
  logic [WORD_W-1:0] w_rd;

  // Error check runs on the latched request, so late input changes cannot affect it.
  assign w_widx   = word_index(r_addr);
  assign w_err    = (r_addr[1:0] != 2'b00) || ({2'b00, w_widx} >= 32'(DEPTH_WORDS));
  assign w_access = (r_state == BUSY) && (r_cnt == '0);
  assign w_we     = w_access && r_write && !w_err;

  mem_word_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_be    (r_be),
    .i_idx   (w_widx[AW-1:0]),
    .i_wdata (r_wdata),
    .o_rdata (w_rd)
  );

  // Request FSM: latch on accept, count down the latency, hold the response until taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_err       <= ERR_NONE;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid && r_req_ready) begin
            r_write     <= bus.req_write;
            r_addr      <= bus.req_addr;
            r_wdata     <= bus.req_wdata;
            r_be        <= bus.req_be;
            r_cnt       <= CW'(LATENCY - 1);
            r_req_ready <= 1'b0;
            r_state     <= BUSY;
          end
        end
        BUSY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_rdata     <= (w_err || r_write) ? '0 : w_rd;
            r_err       <= w_err ? ERR_SET : ERR_NONE;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
            r_err       <= ERR_NONE;
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;

endmodule
